// File: rtl/seq_signed_divider_pkg.sv
// ============================================================================
// seq_signed_divider_pkg : shared widths, FSM encoding and special-case constants
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_signed_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [DEFAULT_WIDTH-1:0] MIN_NEG = DEFAULT_WIDTH'(1) << (DEFAULT_WIDTH - 1);

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_signed_divider_div_step.sv
// ============================================================================
// seq_signed_divider_div_step : one combinational non-restoring division step
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_signed_divider_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] rem_in,
  input  logic           in_bit,
  input  logic [WIDTH:0] dvs,
  output logic [WIDTH:0] rem_out,
  output logic           q_bit
);

  logic [WIDTH:0] shifted;

  // Arithmetic is modulo 2^(WIDTH+1); the true result always fits, so the
  // bit lost by the shift never matters.
  always_comb begin
    shifted = {rem_in[WIDTH-1:0], in_bit};
    rem_out = rem_in[WIDTH] ? (shifted + dvs) : (shifted - dvs);
    q_bit   = ~rem_out[WIDTH];
  end

endmodule

`default_nettype wire

// File: rtl/seq_signed_divider.sv
// ============================================================================
// seq_signed_divider : multi-cycle signed divider, fixed WIDTH+2 cycle latency
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG_W = {1'b1, {(WIDTH-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]  rem_q, rem_d;
  logic [WIDTH:0]  dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic            dvs_neg_q, dvs_neg_d;
  logic [WIDTH-1:0] fix_quo_q, fix_quo_d, fix_rem_q, fix_rem_d;
  logic            fix_ovf_q, fix_ovf_d, fix_dbz_q, fix_dbz_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic            overflow_q, overflow_d, dbz_q, dbz_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] rem_mag;

  seq_signed_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .in_bit  (quo_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    dividend_d  = dividend_q;
    dvs_neg_d   = dvs_neg_q;
    fix_quo_d   = fix_quo_q;
    fix_rem_d   = fix_rem_q;
    fix_ovf_d   = fix_ovf_q;
    fix_dbz_d   = fix_dbz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    overflow_d  = overflow_q;
    dbz_d       = dbz_q;
    rem_mag     = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + dvs_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

    case (state_q)
      IDLE: begin
        busy_d = start;
        if (start) begin
          dividend_d = dividend;
          dvs_neg_d  = divisor[WIDTH-1];
          // Magnitude of MIN_NEG is exact when read as unsigned.
          quo_d      = dividend[WIDTH-1] ? -dividend : dividend;
          dvs_d      = {1'b0, (divisor[WIDTH-1] ? -divisor : divisor)};
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        fix_ovf_d = 1'b0;
        fix_dbz_d = 1'b0;
        fix_quo_d = (dividend_q[WIDTH-1] ^ dvs_neg_q) ? -quo_q : quo_q;
        fix_rem_d = dividend_q[WIDTH-1] ? -rem_mag : rem_mag;
        if (dvs_q == '0) begin
          fix_dbz_d = 1'b1;
          fix_quo_d = '0;
          fix_rem_d = dividend_q;
        end else if (dividend_q == MIN_NEG_W && dvs_neg_q && dvs_q == (WIDTH+1)'(1)) begin
          fix_ovf_d = 1'b1;
          fix_quo_d = MIN_NEG_W;
          fix_rem_d = '0;
        end
        state_d = DONE;
      end
      DONE: begin
        quotient_d  = fix_quo_q;
        remainder_d = fix_rem_q;
        overflow_d  = fix_ovf_q;
        dbz_d       = fix_dbz_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      dividend_q  <= '0;
      dvs_neg_q   <= 1'b0;
      fix_quo_q   <= '0;
      fix_rem_q   <= '0;
      fix_ovf_q   <= 1'b0;
      fix_dbz_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      dividend_q  <= dividend_d;
      dvs_neg_q   <= dvs_neg_d;
      fix_quo_q   <= fix_quo_d;
      fix_rem_q   <= fix_rem_d;
      fix_ovf_q   <= fix_ovf_d;
      fix_dbz_q   <= fix_dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      overflow_q  <= overflow_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire
